// File: rtl/led_display_scheduler.sv
// Shares the 8-LED bar between a bouncing scan dot and a volume bar graph, with a built-in step prescaler.
// Optional peak-hold marker is enabled by defining PEAK_HOLD_EN.
module led_display_scheduler #(
   parameter int TICK_DIV   = 50_000_000,
   parameter int HOLD_TICKS = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       vol_valid,
   output logic       vol_ready,
   input  logic [3:0] vol_level,
   output logic       step_tick,
   output logic       mode,
   output logic [7:0] LEDR
);

   // state  | meaning
   // SCAN   | LEDR shows the bouncing dot at pos
   // VOLUME | LEDR shows the bar for lvl; pos/dir frozen until hold expires
   typedef enum logic {SCAN = 1'b0, VOLUME = 1'b1} state_t;

   localparam int CNT_W  = $clog2(TICK_DIV);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   state_t            state_q, state_nx;
   logic [CNT_W-1:0]  cnt_q;
   logic              tick_q;
   logic [2:0]        pos_q, pos_nx;
   logic              dir_q, dir_nx;
   logic [3:0]        lvl_q, lvl_nx;
   logic [HOLD_W-1:0] hold_q, hold_nx;
   logic [7:0]        led_nx;
   logic [3:0]        lvl_clamped;
   logic              accept;
   logic              step;
`ifdef PEAK_HOLD_EN
   logic [3:0]        peak_q, peak_nx;
`endif

   assign lvl_clamped = (vol_level > 4'd8) ? 4'd8 : vol_level;
   assign accept      = vol_valid & vol_ready;
   assign step        = tick_q & enable;
   assign step_tick   = step;
   assign mode        = (state_q == VOLUME);

   always_comb begin
      state_nx = state_q;
      pos_nx   = pos_q;
      dir_nx   = dir_q;
      lvl_nx   = lvl_q;
      hold_nx  = hold_q;
`ifdef PEAK_HOLD_EN
      peak_nx  = peak_q;
      if (accept && lvl_clamped > peak_q)
         peak_nx = lvl_clamped;
      else if (!accept && step && state_q == SCAN && peak_q != 4'd0)
         peak_nx = peak_q - 4'd1;
`endif
      // Accept always wins over a coincident step, in either state.
      if (accept) begin
         state_nx = VOLUME;
         lvl_nx   = lvl_clamped;
         hold_nx  = HOLD_W'(HOLD_TICKS);
      end else if (step) begin
         unique case (state_q)
            SCAN: begin
               if (!dir_q) begin
                  if (pos_q == 3'd7) begin
                     pos_nx = 3'd6;
                     dir_nx = 1'b1;
                  end else begin
                     pos_nx = pos_q + 3'd1;
                  end
               end else begin
                  if (pos_q == 3'd0) begin
                     pos_nx = 3'd1;
                     dir_nx = 1'b0;
                  end else begin
                     pos_nx = pos_q - 3'd1;
                  end
               end
            end
            VOLUME: begin
               if (hold_q == HOLD_W'(1))
                  state_nx = SCAN;
               else
                  hold_nx = hold_q - HOLD_W'(1);
            end
            default: state_nx = SCAN;
         endcase
      end
   end

   always_comb begin
      led_nx = 8'h00;
      if (state_nx == VOLUME) begin
         for (int i = 0; i < 8; i++)
            led_nx[i] = (4'(i) < lvl_nx);
`ifdef PEAK_HOLD_EN
         if (peak_nx > lvl_nx)
            led_nx[3'(peak_nx - 4'd1)] = 1'b1;
`endif
      end else begin
         led_nx = 8'h01 << pos_nx;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else if (enable) begin
         if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
         end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            tick_q <= 1'b0;
         end
      end else begin
         tick_q <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= SCAN;
         pos_q     <= 3'd0;
         dir_q     <= 1'b0;
         lvl_q     <= 4'd0;
         hold_q    <= '0;
         vol_ready <= 1'b0;
         LEDR      <= 8'h01;
`ifdef PEAK_HOLD_EN
         peak_q    <= 4'd0;
`endif
      end else begin
         state_q   <= state_nx;
         pos_q     <= pos_nx;
         dir_q     <= dir_nx;
         lvl_q     <= lvl_nx;
         hold_q    <= hold_nx;
         vol_ready <= 1'b1;
         LEDR      <= led_nx;
`ifdef PEAK_HOLD_EN
         peak_q    <= peak_nx;
`endif
      end
   end

endmodule

// File: tb/tb_led_display_scheduler.sv
// Randomized scoreboard bench for led_display_scheduler against a sweep-phase reference model.
module tb_led_display_scheduler;
   localparam int TICK_DIV   = 4;
   localparam int HOLD_TICKS = 3;

   logic       clock = 1'b0;
   logic       reset, enable, vol_valid, vol_ready, step_tick, mode;
   logic [3:0] vol_level;
   logic [7:0] LEDR;

   led_display_scheduler #(.TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)) dut (
      .clock(clock), .reset(reset), .enable(enable), .vol_valid(vol_valid),
      .vol_ready(vol_ready), .vol_level(vol_level), .step_tick(step_tick),
      .mode(mode), .LEDR(LEDR)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] led;
      logic       mode;
      logic       tick;
      logic       ready;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   running = 1'b0;

   // Reference state: scan is a phase 0..13 around the 14-step sweep.
   int m_ph, m_e, m_lvl, m_hold, m_peak;
   bit m_vol, m_tickq, m_ready;

   function automatic logic [7:0] model_led();
      logic [7:0] v;
      int p;
      if (m_vol) begin
         v = 8'((1 << m_lvl) - 1);
`ifdef PEAK_HOLD_EN
         if (m_peak > m_lvl) v = v | 8'(1 << (m_peak - 1));
`endif
      end else begin
         p = (m_ph <= 7) ? m_ph : 14 - m_ph;
         v = 8'(1 << p);
      end
      return v;
   endfunction

   task automatic cycle(input bit rst, input bit en, input bit v, input logic [3:0] lvl);
      exp_t e;
      bit   stp, acc;
      int   cl;
      reset = rst; enable = en; vol_valid = v; vol_level = lvl;
      if (rst) begin
         m_ph = 0; m_vol = 0; m_e = 0; m_tickq = 0; m_ready = 0;
         m_lvl = 0; m_hold = 0; m_peak = 0;
      end else begin
         stp = m_tickq && en;
         acc = v && m_ready;
         cl  = (lvl > 8) ? 8 : int'(lvl);
         if (acc) begin
            if (cl > m_peak) m_peak = cl;
            m_vol = 1; m_lvl = cl; m_hold = HOLD_TICKS;
         end else if (stp) begin
            if (m_vol) begin
               if (m_hold == 1) m_vol = 0;
               else m_hold--;
            end else begin
               m_ph = (m_ph + 1) % 14;
               if (m_peak > 0) m_peak--;
            end
         end
         if (en) begin
            m_e++;
            m_tickq = (m_e % TICK_DIV == 0);
         end else begin
            m_tickq = 0;
         end
         m_ready = 1;
      end
      e.led = model_led(); e.mode = m_vol; e.tick = m_tickq && en; e.ready = m_ready;
      exp_q.push_back(e);
      @(negedge clock);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(posedge clock) begin
      #1;
      if (running) begin
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("LEDR",      int'(LEDR),      int'(e.led));
            chk("mode",      int'(mode),      int'(e.mode));
            chk("step_tick", int'(step_tick), int'(e.tick));
            chk("vol_ready", int'(vol_ready), int'(e.ready));
         end
      end
   end

   initial begin
      bit rst, en, v;
      running = 1'b1;
      cycle(1, 0, 0, 4'd0);
      cycle(1, 0, 0, 4'd0);
      for (int i = 0; i < 60; i++) cycle(0, 1, 0, 4'd0);
      // Accept 5 right after the dot reaches bit 4, then let it expire.
      for (int i = 0; i < 200 && !(m_ph == 4 && !m_vol); i++) cycle(0, 1, 0, 4'd0);
      cycle(0, 1, 1, 4'd5);
      for (int i = 0; i < 20; i++) cycle(0, 1, 0, 4'd0);
      // Clamp, then accept on the expiring step.
      cycle(0, 1, 1, 4'd12);
      for (int i = 0; i < 40 && !(m_vol && m_hold == 1 && m_tickq); i++) cycle(0, 1, 0, 4'd0);
      cycle(0, 1, 1, 4'd0);
      cycle(0, 1, 0, 4'd0);
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 4'd0);
      for (int i = 0; i < 20; i++) cycle(0, 1, 0, 4'd0);
      // Reset while in VOLUME.
      cycle(0, 1, 1, 4'd6);
      cycle(1, 1, 0, 4'd0);
      cycle(0, 1, 0, 4'd0);
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         en  = ($urandom_range(0, 9) != 0);
         v   = ($urandom_range(0, 11) == 0);
         if (m_vol && m_hold == 1 && m_tickq && en) v = $urandom_range(0, 1);
         cycle(rst, en, v, 4'($urandom_range(0, 15)));
      end
      running = 1'b0;
      if (exp_q.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
